fifo_wr_sched: RTL and testbench

- Write-side scheduler for the async FIFO. Runs in the FIFO write-clock domain and drives its W_INC/WR_DATA port.
- Shares the single byte-wide FIFO write port between two producers:
  - ALU: 2-byte results, serialized LSB then MSB.
  - Register file: single-byte read data.
- Honours the FIFO full flag. Each producer gets a one-entry holding buffer with a ready/valid handshake.

---
 rtl/fifo_sched_pkg.sv | 27 ++
 rtl/hold_buf.sv | 43 ++++
 rtl/fifo_wr_sched.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO write-side scheduler: state encoding,
// arbitration mode constants and the statistics counter helper.
package fifo_sched_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ALU_LSB = 2'd1;
  localparam logic [1:0] ST_ALU_MSB = 2'd2;
  localparam logic [1:0] ST_RF_BYTE = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StAluLsb = ST_ALU_LSB,
    StAluMsb = ST_ALU_MSB,
    StRfByte = ST_RF_BYTE
  } sched_state_e;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  localparam int unsigned CNT_W = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hold_buf.sv
// One-entry ready/valid holding register: captures when empty, empties on release.
module hold_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  input  logic             release_i,
  output logic             ready_o,
  output logic [Width-1:0] data_o
);

  logic             full_d, full_q;
  logic [Width-1:0] data_d, data_q;

  // READY comes straight from the register, so capture and release can never
  // coincide: capture needs empty, release needs full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (release_i && full_q) begin
      full_d = 1'b0;
    end else if (valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready_o = ~full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fifo_wr_sched.sv
// Write-side scheduler sharing one byte-wide FIFO write port between the ALU
// (2-byte frames) and the register file. FIFO_WR_SCHED_STATS_EN adds counters.
module fifo_wr_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ALU_WIDTH  = 2 * DATA_WIDTH,
  parameter int unsigned ARB_MODE   = 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_ALU_VALID,
  input  logic [ALU_WIDTH-1:0]  i_ALU_DATA,
  output logic                  o_ALU_READY,
  input  logic                  i_RF_VALID,
  input  logic [DATA_WIDTH-1:0] i_RF_DATA,
  output logic                  o_RF_READY,
  input  logic                  i_FIFO_FULL,
  output logic                  o_W_INC,
  output logic [DATA_WIDTH-1:0] o_WR_DATA,
  output logic                  o_BUSY
`ifdef FIFO_WR_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]      o_BYTE_CNT,
  output logic [CNT_W-1:0]      o_STALL_CNT
`endif
);

  sched_state_e          state_d, state_q;
  logic                  last_rf_d, last_rf_q;
  logic                  alu_rel, rf_rel;
  logic                  alu_ready, rf_ready;
  logic                  alu_full, rf_full;
  logic                  w_inc, busy;
  logic [ALU_WIDTH-1:0]  alu_buf;
  logic [DATA_WIDTH-1:0] rf_buf;

  hold_buf #(.Width(ALU_WIDTH)) u_alu_buf (
    .clk_i    (i_CLK),
    .rst_ni   (i_RST),
    .valid_i  (i_ALU_VALID),
    .data_i   (i_ALU_DATA),
    .release_i(alu_rel),
    .ready_o  (alu_ready),
    .data_o   (alu_buf)
  );

  hold_buf #(.Width(DATA_WIDTH)) u_rf_buf (
    .clk_i    (i_CLK),
    .rst_ni   (i_RST),
    .valid_i  (i_RF_VALID),
    .data_i   (i_RF_DATA),
    .release_i(rf_rel),
    .ready_o  (rf_ready),
    .data_o   (rf_buf)
  );

  assign alu_full = ~alu_ready;
  assign rf_full  = ~rf_ready;
  assign busy     = (state_q != StIdle);
  assign w_inc    = busy & ~i_FIFO_FULL;

  // The pointer tracks the winner of IDLE arbitration; frame-end handoffs have
  // only one possible candidate and leave it untouched.
  always_comb begin
    state_d   = state_q;
    last_rf_d = last_rf_q;
    alu_rel   = 1'b0;
    rf_rel    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (alu_full && rf_full) begin
          if ((ARB_MODE == ARB_RR) && !last_rf_q) begin
            state_d   = StRfByte;
            last_rf_d = 1'b1;
          end else begin
            state_d   = StAluLsb;
            last_rf_d = 1'b0;
          end
        end else if (alu_full) begin
          state_d   = StAluLsb;
          last_rf_d = 1'b0;
        end else if (rf_full) begin
          state_d   = StRfByte;
          last_rf_d = 1'b1;
        end
      end
      StAluLsb: begin
        if (w_inc) state_d = StAluMsb;
      end
      StAluMsb: begin
        if (w_inc) begin
          alu_rel = 1'b1;
          state_d = rf_full ? StRfByte : StIdle;
        end
      end
      StRfByte: begin
        if (w_inc) begin
          rf_rel  = 1'b1;
          state_d = alu_full ? StAluLsb : StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q   <= StIdle;
      last_rf_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_rf_q <= last_rf_d;
    end
  end

  always_comb begin
    o_WR_DATA = '0;
    unique case (state_q)
      StIdle:   o_WR_DATA = '0;
      StAluLsb: o_WR_DATA = alu_buf[DATA_WIDTH-1:0];
      StAluMsb: o_WR_DATA = alu_buf[ALU_WIDTH-1:DATA_WIDTH];
      StRfByte: o_WR_DATA = rf_buf;
    endcase
  end

  assign o_W_INC     = w_inc;
  assign o_BUSY      = busy;
  assign o_ALU_READY = alu_ready;
  assign o_RF_READY  = rf_ready;

`ifdef FIFO_WR_SCHED_STATS_EN
  logic [CNT_W-1:0] byte_cnt_q, stall_cnt_q;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (w_inc) byte_cnt_q <= sat_inc(byte_cnt_q);
      if (busy && i_FIFO_FULL) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign o_BYTE_CNT  = byte_cnt_q;
  assign o_STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Bench for fifo_wr_sched: fixed-priority and round-robin instances against a
// frame-level reference model; checks stats ports when FIFO_WR_SCHED_STATS_EN is set.
module tb_fifo_wr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       full;
  logic       alu_v   [2];
  logic [15:0] alu_dat [2];
  logic       rf_v    [2];
  logic [7:0] rf_dat  [2];
  logic       alu_rdy [2];
  logic       rf_rdy  [2];
  logic       winc    [2];
  logic       busy    [2];
  logic [7:0] wdat    [2];
`ifdef FIFO_WR_SCHED_STATS_EN
  logic [15:0] bcnt [2];
  logic [15:0] scnt [2];
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: pending flags/data per producer, the frame being sent
  // (source and bytes left), round-robin memory and counters.
  bit          m_alu_p [2];
  logic [15:0] m_alu_d [2];
  bit          m_rf_p  [2];
  logic [7:0]  m_rf_d  [2];
  int          m_src   [2];  // 0 none, 1 ALU, 2 RF
  int          m_cnt   [2];  // bytes of current frame still to write
  bit          m_last_rf [2];
  int          m_bc [2];
  int          m_sc [2];
  logic [7:0]  wlog [2][64];
  int          wn [2];

  fifo_wr_sched #(.DATA_WIDTH(8), .ALU_WIDTH(16), .ARB_MODE(0)) dut0 (
    .i_CLK(clk), .i_RST(rst_n),
    .i_ALU_VALID(alu_v[0]), .i_ALU_DATA(alu_dat[0]), .o_ALU_READY(alu_rdy[0]),
    .i_RF_VALID(rf_v[0]), .i_RF_DATA(rf_dat[0]), .o_RF_READY(rf_rdy[0]),
    .i_FIFO_FULL(full), .o_W_INC(winc[0]), .o_WR_DATA(wdat[0]), .o_BUSY(busy[0])
`ifdef FIFO_WR_SCHED_STATS_EN
    , .o_BYTE_CNT(bcnt[0]), .o_STALL_CNT(scnt[0])
`endif
  );

  fifo_wr_sched #(.DATA_WIDTH(8), .ALU_WIDTH(16), .ARB_MODE(1)) dut1 (
    .i_CLK(clk), .i_RST(rst_n),
    .i_ALU_VALID(alu_v[1]), .i_ALU_DATA(alu_dat[1]), .o_ALU_READY(alu_rdy[1]),
    .i_RF_VALID(rf_v[1]), .i_RF_DATA(rf_dat[1]), .o_RF_READY(rf_rdy[1]),
    .i_FIFO_FULL(full), .o_W_INC(winc[1]), .o_WR_DATA(wdat[1]), .o_BUSY(busy[1])
`ifdef FIFO_WR_SCHED_STATS_EN
    , .o_BYTE_CNT(bcnt[1]), .o_STALL_CNT(scnt[1])
`endif
  );

  task automatic chk(input string tag, input int d, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_byte(input int d);
    if (m_cnt[d] == 0) return 8'h00;
    if (m_src[d] == 1) return (m_cnt[d] == 2) ? m_alu_d[d][7:0] : m_alu_d[d][15:8];
    return m_rf_d[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_alu_p[d] = 0; m_rf_p[d] = 0; m_src[d] = 0; m_cnt[d] = 0;
      m_last_rf[d] = 1; m_bc[d] = 0; m_sc[d] = 0;
      m_alu_d[d] = '0; m_rf_d[d] = '0;
    end
  endtask

  task automatic model_step();
    bit ra, rr, idle, w, pick_alu;
    for (int d = 0; d < 2; d++) begin
      ra   = !m_alu_p[d];
      rr   = !m_rf_p[d];
      idle = (m_cnt[d] == 0);
      w    = !idle && !full;
      if (w) begin
        if (wn[d] < 64) wlog[d][wn[d]] = m_byte(d);
        wn[d]++;
        m_cnt[d]--;
        if (m_bc[d] < 65535) m_bc[d]++;
      end
      if (!idle && full && m_sc[d] < 65535) m_sc[d]++;
      if (idle) begin
        if (m_alu_p[d] && m_rf_p[d]) pick_alu = (d == 0) ? 1'b1 : m_last_rf[d];
        else pick_alu = m_alu_p[d];
        if (m_alu_p[d] || m_rf_p[d]) begin
          if (pick_alu) begin m_src[d] = 1; m_cnt[d] = 2; m_last_rf[d] = 0; end
          else          begin m_src[d] = 2; m_cnt[d] = 1; m_last_rf[d] = 1; end
        end
      end else if (w && m_cnt[d] == 0) begin
        if (m_src[d] == 1) begin
          m_alu_p[d] = 0;
          if (m_rf_p[d]) begin m_src[d] = 2; m_cnt[d] = 1; end else m_src[d] = 0;
        end else begin
          m_rf_p[d] = 0;
          if (m_alu_p[d]) begin m_src[d] = 1; m_cnt[d] = 2; end else m_src[d] = 0;
        end
      end
      if (alu_v[d] && ra) begin m_alu_p[d] = 1; m_alu_d[d] = alu_dat[d]; alu_v[d] = 0; end
      if (rf_v[d] && rr)  begin m_rf_p[d] = 1;  m_rf_d[d] = rf_dat[d];   rf_v[d] = 0;  end
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("w_inc", d, 16'(winc[d]), 16'(m_cnt[d] != 0 && !full));
      chk("wr_data", d, 16'(wdat[d]), 16'(m_byte(d)));
      chk("busy", d, 16'(busy[d]), 16'(m_cnt[d] != 0));
      chk("alu_ready", d, 16'(alu_rdy[d]), 16'(!m_alu_p[d]));
      chk("rf_ready", d, 16'(rf_rdy[d]), 16'(!m_rf_p[d]));
`ifdef FIFO_WR_SCHED_STATS_EN
      chk("byte_cnt", d, bcnt[d], 16'(m_bc[d]));
      chk("stall_cnt", d, scnt[d], 16'(m_sc[d]));
`endif
    end
  endtask

  // One cycle: inputs were set just after the previous edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    full = 1'b0;
    for (int d = 0; d < 2; d++) begin
      alu_v[d] = 1'b0; rf_v[d] = 1'b0; alu_dat[d] = '0; rf_dat[d] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    wn[0] = 0; wn[1] = 0;
    ticks(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic put_alu(input logic [15:0] v);
    for (int d = 0; d < 2; d++) begin alu_v[d] = 1'b1; alu_dat[d] = v; end
  endtask

  task automatic put_rf(input logic [7:0] v);
    for (int d = 0; d < 2; d++) begin rf_v[d] = 1'b1; rf_dat[d] = v; end
  endtask

  logic [7:0] exp_fix [6];
  logic [7:0] exp_rr  [6];

  initial begin
    exp_fix = '{8'hB0, 8'hA0, 8'h55, 8'hD0, 8'hC0, 8'h66};
    exp_rr  = '{8'hB0, 8'hA0, 8'h55, 8'h66, 8'hD0, 8'hC0};
    wn[0] = 0; wn[1] = 0;
    do_reset();

    // ALU-only frame.
    put_alu(16'h1234);
    ticks(6);
    for (int d = 0; d < 2; d++) begin
      chk("alu_only_cnt", d, 16'(wn[d]), 16'd2);
      chk("alu_only_lsb", d, 16'(wlog[d][0]), 16'h0034);
      chk("alu_only_msb", d, 16'(wlog[d][1]), 16'h0012);
    end

    // Full asserted for 3 cycles while the MSB is up.
    wn[0] = 0; wn[1] = 0;
    put_alu(16'h5678);
    ticks(3);
    full = 1'b1;
    ticks(3);
    full = 1'b0;
    ticks(3);
    // Single RF byte: 5 written bytes and 3 stalls since reset.
    put_rf(8'h99);
    ticks(4);
    for (int d = 0; d < 2; d++) begin
      chk("full_seq_cnt", d, 16'(wn[d]), 16'd3);
      chk("full_seq_lsb", d, 16'(wlog[d][0]), 16'h0078);
      chk("full_seq_msb", d, 16'(wlog[d][1]), 16'h0056);
      chk("full_seq_rf", d, 16'(wlog[d][2]), 16'h0099);
`ifdef FIFO_WR_SCHED_STATS_EN
      chk("stats_bytes5", d, bcnt[d], 16'd5);
      chk("stats_stall3", d, scnt[d], 16'd3);
`endif
    end

    // Two ties from a fresh round-robin pointer.
    do_reset();
    put_alu(16'hA0B0);
    put_rf(8'h55);
    ticks(6);
    put_alu(16'hC0D0);
    put_rf(8'h66);
    ticks(6);
    for (int d = 0; d < 2; d++) chk("tie_cnt", d, 16'(wn[d]), 16'd6);
    for (int k = 0; k < 6; k++) begin
      chk("tie_fixed", 0, 16'(wlog[0][k]), 16'(exp_fix[k]));
      chk("tie_rr", 1, 16'(wlog[1][k]), 16'(exp_rr[k]));
    end

    // Async reset while in ALU_MSB with the RF buffer full.
    do_reset();
    put_alu(16'hBEEF);
    put_rf(8'h77);
    ticks(3);
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_w_inc", d, 16'(winc[d]), 16'd0);
      chk("rst_alu_ready", d, 16'(alu_rdy[d]), 16'd1);
      chk("rst_rf_ready", d, 16'(rf_rdy[d]), 16'd1);
      chk("rst_busy", d, 16'(busy[d]), 16'd0);
      chk("rst_wr_data", d, 16'(wdat[d]), 16'd0);
    end
    clear_inputs();
    model_reset();
    wn[0] = 0; wn[1] = 0;
    @(posedge clk);
    #1;
    tick();
    rst_n = 1'b1;
    ticks(5);
    for (int d = 0; d < 2; d++) chk("rst_no_writes", d, 16'(wn[d]), 16'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (!alu_v[d] && $urandom_range(0, 2) == 0) begin
          alu_v[d] = 1'b1; alu_dat[d] = 16'($urandom);
        end
        if (!rf_v[d] && $urandom_range(0, 2) == 0) begin
          rf_v[d] = 1'b1; rf_dat[d] = 8'($urandom);
        end
      end
      full = ($urandom_range(0, 3) == 0);
      tick();
    end
    clear_inputs();
    ticks(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
